hood_ctrl_fsm: RTL and testbench

Clocked, parametrised range-hood controller FSM driven by single-cycle button pulses (A/S/W/X/D).
- Owns the power, menu, fan-speed, storm, clean, search and time-setting modes.
- Keeps the BCD work-time, reminder and idle-switch timers.
- Sits between the button edge-detect/debounce block and the display/fan-driver blocks.
- Supersedes the edge-triggered multi-process controller: one clock domain, N speed levels, timed storm/clean, shadowed time editing, reminder alarm.

---
 rtl/hood_pkg.sv | 54 +++++
 rtl/bcd_clock_inc.sv | 25 ++
 rtl/hood_ctrl_fsm.sv | 261 ++++++++++++++++++++++++++
 tb/tb_hood_ctrl_fsm.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// Shared state codes, edit-target enum and BCD helpers for the range-hood controller.
// Combinational helpers only; no latency and no flow control.
package hood_pkg;

    localparam logic [6:0] ST_SHUTDOWN    = 7'd0;
    localparam logic [6:0] ST_STANDBY     = 7'd1;
    localparam logic [6:0] ST_MENU        = 7'd2;
    localparam logic [6:0] ST_RUN         = 7'd3;
    localparam logic [6:0] ST_STORM       = 7'd4;
    localparam logic [6:0] ST_CLEAN       = 7'd5;
    localparam logic [6:0] ST_SEARCH      = 7'd6;
    localparam logic [6:0] ST_SHOW_WORK   = 7'd7;
    localparam logic [6:0] ST_SHOW_SWITCH = 7'd8;
    localparam logic [6:0] ST_SHOW_REMIND = 7'd9;
    localparam logic [6:0] ST_SET_HOUR    = 7'd10;
    localparam logic [6:0] ST_SET_MIN     = 7'd11;
    localparam logic [6:0] ST_SET_SEC     = 7'd12;

    typedef enum logic [6:0] {
        SHUTDOWN    = ST_SHUTDOWN,
        STANDBY     = ST_STANDBY,
        MENU        = ST_MENU,
        RUN         = ST_RUN,
        STORM       = ST_STORM,
        CLEAN       = ST_CLEAN,
        SEARCH      = ST_SEARCH,
        SHOW_WORK   = ST_SHOW_WORK,
        SHOW_SWITCH = ST_SHOW_SWITCH,
        SHOW_REMIND = ST_SHOW_REMIND,
        SET_HOUR    = ST_SET_HOUR,
        SET_MIN     = ST_SET_MIN,
        SET_SEC     = ST_SET_SEC
    } state_e;

    typedef enum logic {TGT_SWITCH, TGT_REMIND} tgt_e;

    typedef enum logic [2:0] {BTN_NONE, BTN_W, BTN_X, BTN_S, BTN_A, BTN_D} btn_e;

    // Two-digit BCD increment; anything at or above max_val wraps to 00.
    function automatic logic [7:0] bcd_inc_field(input logic [7:0] value, input logic [7:0] max_val);
        if (value >= max_val) return 8'h00;
        if (value[3:0] >= 4'd9) return {value[7:4] + 4'd1, 4'd0};
        return value + 8'd1;
    endfunction

    function automatic logic [19:0] bcd_to_sec(input logic [23:0] hhmmss);
        logic [19:0] h, m, s;
        h = 20'(hhmmss[23:20]) * 20'd10 + 20'(hhmmss[19:16]);
        m = 20'(hhmmss[15:12]) * 20'd10 + 20'(hhmmss[11:8]);
        s = 20'(hhmmss[7:4])   * 20'd10 + 20'(hhmmss[3:0]);
        return h * 20'd3600 + m * 20'd60 + s;
    endfunction

endpackage

// File: rtl/bcd_clock_inc.sv
// BCD hh:mm:ss plus one second, holding at HOUR_MAX:59:59.
// Purely combinational; no backpressure.
module bcd_clock_inc
    import hood_pkg::*;
#(
    parameter logic [7:0] HOUR_MAX = 8'h99
) (
    input  logic [23:0] time_i,
    output logic [23:0] time_o
);

    always_comb begin
        time_o = time_i;
        if (time_i != {HOUR_MAX, 8'h59, 8'h59}) begin
            time_o[7:0] = bcd_inc_field(time_i[7:0], 8'h59);
            if (time_i[7:0] == 8'h59) begin
                time_o[15:8] = bcd_inc_field(time_i[15:8], 8'h59);
                if (time_i[15:8] == 8'h59) begin
                    time_o[23:16] = bcd_inc_field(time_i[23:16], HOUR_MAX);
                end
            end
        end
    end

endmodule

// File: rtl/hood_ctrl_fsm.sv
// Range-hood controller: power/menu/fan/storm/clean/search/time-edit FSM with BCD timers.
// All outputs registered, 1-cycle latency from pulse; HOOD_AUTO_OFF_EN adds STANDBY idle auto-off.
module hood_ctrl_fsm
    import hood_pkg::*;
#(
    parameter int SPEED_LEVELS = 3,
    parameter int STORM_SEC    = 60,
    parameter int CLEAN_SEC    = 180,
    parameter int TICK_DIV     = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_a,
    input  logic        btn_s,
    input  logic        btn_w,
    input  logic        btn_x,
    input  logic        btn_d,
    output logic [6:0]  state,
    output logic [2:0]  speed,
    output logic        storm_used,
    output logic [23:0] work_time,
    output logic [23:0] remind_time,
    output logic [23:0] switch_time,
    output logic [23:0] edit_time,
    output logic        remind_alarm
);

    localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CD_MAX = (STORM_SEC > CLEAN_SEC) ? STORM_SEC : CLEAN_SEC;
    localparam int CW     = $clog2(CD_MAX + 1);
    localparam logic [2:0] SPD_MAX = 3'(SPEED_LEVELS);

    state_e        state_q, state_d;
    logic [2:0]    speed_q, speed_d;
    logic          storm_used_q, storm_used_d;
    logic [23:0]   work_q, work_d, work_inc;
    logic [23:0]   remind_q, remind_d;
    logic [23:0]   switch_q, switch_d;
    logic [23:0]   edit_q, edit_d;
    logic          alarm_q, alarm_d;
    tgt_e          tgt_q, tgt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [CW-1:0] cd_q, cd_d;
    logic          tick;
    logic          clean_done;
    btn_e          btn;
    state_e        show_st;
`ifdef HOOD_AUTO_OFF_EN
    logic [19:0]   idle_q, idle_d;
`endif

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign show_st    = (tgt_q == TGT_SWITCH) ? SHOW_SWITCH : SHOW_REMIND;

    // Only the highest-priority pulse acts, even if it is meaningless in the current state.
    always_comb begin
        btn = BTN_NONE;
        if (btn_w)      btn = BTN_W;
        else if (btn_x) btn = BTN_X;
        else if (btn_s) btn = BTN_S;
        else if (btn_a) btn = BTN_A;
        else if (btn_d) btn = BTN_D;
    end

    bcd_clock_inc #(.HOUR_MAX(8'h99)) u_work_inc (
        .time_i (work_q),
        .time_o (work_inc)
    );

    always_comb begin
        state_d      = state_q;
        speed_d      = speed_q;
        storm_used_d = storm_used_q;
        work_d       = work_q;
        remind_d     = remind_q;
        switch_d     = switch_q;
        edit_d       = edit_q;
        tgt_d        = tgt_q;
        cd_d         = cd_q;
        clean_done   = 1'b0;
        alarm_d      = alarm_q;
`ifdef HOOD_AUTO_OFF_EN
        idle_d       = '0;
`endif

        if (tick && (state_q == RUN || state_q == STORM)) work_d = work_inc;

        case (state_q)
            SHUTDOWN: if (btn == BTN_S) state_d = STANDBY;
            STANDBY: begin
                case (btn)
                    BTN_W: state_d = MENU;
                    BTN_X: state_d = SEARCH;
                    BTN_S: begin
                        state_d      = SHUTDOWN;
                        speed_d      = '0;
                        storm_used_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            MENU: begin
                case (btn)
                    BTN_A: begin state_d = RUN; speed_d = 3'd1; end
                    BTN_S: begin state_d = RUN; speed_d = 3'd2; end
                    BTN_D: if (!storm_used_q) begin
                        state_d      = STORM;
                        speed_d      = SPD_MAX;
                        storm_used_d = 1'b1;
                        cd_d         = CW'(STORM_SEC);
                    end
                    BTN_X: begin
                        state_d = CLEAN;
                        speed_d = '0;
                        cd_d    = CW'(CLEAN_SEC);
                    end
                    BTN_W: state_d = STANDBY;
                    default: ;
                endcase
            end
            RUN: begin
                case (btn)
                    BTN_S: if (speed_q < SPD_MAX) speed_d = speed_q + 3'd1;
                    BTN_A: if (speed_q > 3'd1) speed_d = speed_q - 3'd1;
                    BTN_W: begin state_d = STANDBY; speed_d = '0; end
                    default: ;
                endcase
            end
            STORM: begin
                if (tick) cd_d = cd_q - 1'b1;
                if ((tick && cd_q <= CW'(1)) || btn == BTN_W) begin
                    state_d = RUN;
                    speed_d = SPD_MAX;
                end
            end
            CLEAN: begin
                if (tick) begin
                    cd_d = cd_q - 1'b1;
                    if (cd_q <= CW'(1)) begin
                        clean_done = 1'b1;
                        work_d     = '0;
                        state_d    = STANDBY;
                    end
                end
            end
            SEARCH: begin
                case (btn)
                    BTN_A: state_d = SHOW_WORK;
                    BTN_S: state_d = SHOW_SWITCH;
                    BTN_D: state_d = SHOW_REMIND;
                    BTN_W: state_d = STANDBY;
                    default: ;
                endcase
            end
            SHOW_WORK: if (btn == BTN_W) state_d = SEARCH;
            SHOW_SWITCH, SHOW_REMIND: begin
                if (btn == BTN_W) begin
                    state_d = SEARCH;
                end else if (btn == BTN_X) begin
                    state_d = SET_HOUR;
                    tgt_d   = (state_q == SHOW_SWITCH) ? TGT_SWITCH : TGT_REMIND;
                    edit_d  = (state_q == SHOW_SWITCH) ? switch_q : remind_q;
                end
            end
            SET_HOUR, SET_MIN, SET_SEC: begin
                case (btn)
                    BTN_A: begin
                        if (state_q == SET_HOUR)
                            edit_d[23:16] = bcd_inc_field(edit_q[23:16], 8'h23);
                        else if (state_q == SET_MIN)
                            edit_d[15:8] = bcd_inc_field(edit_q[15:8], 8'h59);
                        else
                            edit_d[7:0] = bcd_inc_field(edit_q[7:0], 8'h59);
                    end
                    BTN_S: begin
                        if (state_q == SET_HOUR) begin
                            state_d = SET_MIN;
                        end else if (state_q == SET_MIN) begin
                            state_d = SET_SEC;
                        end else begin
                            if (tgt_q == TGT_SWITCH) switch_d = edit_q;
                            else                     remind_d = edit_q;
                            state_d = show_st;
                        end
                    end
                    BTN_W: state_d = show_st;
                    default: ;
                endcase
            end
            default: state_d = SHUTDOWN;
        endcase

`ifdef HOOD_AUTO_OFF_EN
        // The timeout overrides whatever button acted in the same cycle.
        if (state_q == STANDBY) begin
            if (tick && (idle_q + 20'd1 >= bcd_to_sec(switch_q))) begin
                state_d      = SHUTDOWN;
                speed_d      = '0;
                storm_used_d = 1'b0;
            end else if (btn != BTN_NONE) begin
                idle_d = '0;
            end else if (tick) begin
                idle_d = idle_q + 20'd1;
            end else begin
                idle_d = idle_q;
            end
        end
`endif

        // BCD digits compare correctly as a plain binary magnitude.
        if (clean_done)
            alarm_d = 1'b0;
        else if (remind_d != '0 && work_d >= remind_d)
            alarm_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SHUTDOWN;
            speed_q      <= '0;
            storm_used_q <= 1'b0;
            work_q       <= '0;
            remind_q     <= '0;
            switch_q     <= 24'h000010;
            edit_q       <= '0;
            alarm_q      <= 1'b0;
            tgt_q        <= TGT_SWITCH;
            tick_cnt_q   <= '0;
            cd_q         <= '0;
`ifdef HOOD_AUTO_OFF_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            speed_q      <= speed_d;
            storm_used_q <= storm_used_d;
            work_q       <= work_d;
            remind_q     <= remind_d;
            switch_q     <= switch_d;
            edit_q       <= edit_d;
            alarm_q      <= alarm_d;
            tgt_q        <= tgt_d;
            tick_cnt_q   <= tick_cnt_d;
            cd_q         <= cd_d;
`ifdef HOOD_AUTO_OFF_EN
            idle_q       <= idle_d;
`endif
        end
    end

    assign state        = state_q;
    assign speed        = speed_q;
    assign storm_used   = storm_used_q;
    assign work_time    = work_q;
    assign remind_time  = remind_q;
    assign switch_time  = switch_q;
    assign edit_time    = edit_q;
    assign remind_alarm = alarm_q;

endmodule

// File: tb/tb_hood_ctrl_fsm.sv
// Bench for hood_ctrl_fsm: directed walk through the main flows plus random pulses,
// every cycle compared against a seconds-based reference model.
module tb_hood_ctrl_fsm;
    import hood_pkg::*;

    localparam int SL    = 3;
    localparam int STSEC = 3;
    localparam int CLSEC = 2;
    localparam int TDIV  = 4;
    localparam int MAX_WORK = 99 * 3600 + 59 * 60 + 59;

    localparam logic [4:0] B_N = 5'b00000;
    localparam logic [4:0] B_A = 5'b00001;
    localparam logic [4:0] B_S = 5'b00010;
    localparam logic [4:0] B_W = 5'b00100;
    localparam logic [4:0] B_X = 5'b01000;
    localparam logic [4:0] B_D = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_a = 1'b0, btn_s = 1'b0, btn_w = 1'b0, btn_x = 1'b0, btn_d = 1'b0;
    logic [6:0]  state;
    logic [2:0]  speed;
    logic        storm_used;
    logic [23:0] work_time, remind_time, switch_time, edit_time;
    logic        remind_alarm;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: times kept as plain seconds, edit fields as integers.
    state_e m_st;
    int m_spd, m_work, m_rem, m_sw, m_eh, m_em, m_es, m_phase, m_left, m_idle;
    bit m_used, m_alarm, m_tgt_rem;

    hood_ctrl_fsm #(
        .SPEED_LEVELS (SL),
        .STORM_SEC    (STSEC),
        .CLEAN_SEC    (CLSEC),
        .TICK_DIV     (TDIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_a        (btn_a),
        .btn_s        (btn_s),
        .btn_w        (btn_w),
        .btn_x        (btn_x),
        .btn_d        (btn_d),
        .state        (state),
        .speed        (speed),
        .storm_used   (storm_used),
        .work_time    (work_time),
        .remind_time  (remind_time),
        .switch_time  (switch_time),
        .edit_time    (edit_time),
        .remind_alarm (remind_alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step();
        int win;
        bit tick, clean_done;
        state_e pre;
        if (rst) begin
            m_st = SHUTDOWN; m_spd = 0; m_used = 0; m_work = 0; m_rem = 0; m_sw = 10;
            m_eh = 0; m_em = 0; m_es = 0; m_alarm = 0; m_phase = 0; m_left = 0; m_idle = 0;
            m_tgt_rem = 0;
            return;
        end
        tick = (m_phase % TDIV) == TDIV - 1;
        m_phase++;
        win = btn_w ? 1 : btn_x ? 2 : btn_s ? 3 : btn_a ? 4 : btn_d ? 5 : 0;
        clean_done = 0;
        pre = m_st;
        if (tick && (m_st == RUN || m_st == STORM) && m_work < MAX_WORK) m_work++;
        case (m_st)
            SHUTDOWN: if (win == 3) m_st = STANDBY;
            STANDBY: begin
                if (win == 1) m_st = MENU;
                else if (win == 2) m_st = SEARCH;
                else if (win == 3) begin m_st = SHUTDOWN; m_spd = 0; m_used = 0; end
            end
            MENU: begin
                if (win == 4) begin m_st = RUN; m_spd = 1; end
                else if (win == 3) begin m_st = RUN; m_spd = 2; end
                else if (win == 5 && !m_used) begin m_st = STORM; m_spd = SL; m_used = 1; m_left = STSEC; end
                else if (win == 2) begin m_st = CLEAN; m_spd = 0; m_left = CLSEC; end
                else if (win == 1) m_st = STANDBY;
            end
            RUN: begin
                if (win == 3) m_spd = (m_spd < SL) ? m_spd + 1 : SL;
                else if (win == 4) m_spd = (m_spd > 1) ? m_spd - 1 : 1;
                else if (win == 1) begin m_st = STANDBY; m_spd = 0; end
            end
            STORM: begin
                if (tick) m_left--;
                if ((tick && m_left == 0) || win == 1) begin m_st = RUN; m_spd = SL; end
            end
            CLEAN: begin
                if (tick) m_left--;
                if (tick && m_left == 0) begin clean_done = 1; m_work = 0; m_st = STANDBY; end
            end
            SEARCH: begin
                if (win == 4) m_st = SHOW_WORK;
                else if (win == 3) m_st = SHOW_SWITCH;
                else if (win == 5) m_st = SHOW_REMIND;
                else if (win == 1) m_st = STANDBY;
            end
            SHOW_WORK: if (win == 1) m_st = SEARCH;
            SHOW_SWITCH, SHOW_REMIND: begin
                if (win == 1) m_st = SEARCH;
                else if (win == 2) begin
                    int t;
                    m_tgt_rem = (m_st == SHOW_REMIND);
                    t = m_tgt_rem ? m_rem : m_sw;
                    m_eh = t / 3600; m_em = (t / 60) % 60; m_es = t % 60;
                    m_st = SET_HOUR;
                end
            end
            default: begin
                if (win == 4) begin
                    if (m_st == SET_HOUR) m_eh = (m_eh + 1) % 24;
                    else if (m_st == SET_MIN) m_em = (m_em + 1) % 60;
                    else m_es = (m_es + 1) % 60;
                end else if (win == 3) begin
                    if (m_st == SET_HOUR) m_st = SET_MIN;
                    else if (m_st == SET_MIN) m_st = SET_SEC;
                    else begin
                        if (m_tgt_rem) m_rem = m_eh * 3600 + m_em * 60 + m_es;
                        else m_sw = m_eh * 3600 + m_em * 60 + m_es;
                        m_st = m_tgt_rem ? SHOW_REMIND : SHOW_SWITCH;
                    end
                end else if (win == 1) m_st = m_tgt_rem ? SHOW_REMIND : SHOW_SWITCH;
            end
        endcase
`ifdef HOOD_AUTO_OFF_EN
        if (pre != STANDBY) m_idle = 0;
        else if (tick && m_idle + 1 >= m_sw) begin
            m_st = SHUTDOWN; m_spd = 0; m_used = 0; m_idle = 0;
        end else if (win != 0) m_idle = 0;
        else if (tick) m_idle++;
`endif
        if (clean_done) m_alarm = 0;
        else if (m_rem != 0 && m_work >= m_rem) m_alarm = 1;
    endtask

    task automatic cmp_all();
        chk("state", 32'(state), 32'(m_st));
        chk("speed", 32'(speed), 32'(m_spd));
        chk("storm_used", 32'(storm_used), 32'(m_used));
        chk("work_time", 32'(work_time), 32'(to_bcd(m_work)));
        chk("remind_time", 32'(remind_time), 32'(to_bcd(m_rem)));
        chk("switch_time", 32'(switch_time), 32'(to_bcd(m_sw)));
        chk("remind_alarm", 32'(remind_alarm), 32'(m_alarm));
        if (m_st == SET_HOUR || m_st == SET_MIN || m_st == SET_SEC)
            chk("edit_time", 32'(edit_time), 32'(to_bcd(m_eh * 3600 + m_em * 60 + m_es)));
    endtask

    task automatic step(input logic [4:0] b);
        {btn_d, btn_x, btn_w, btn_s, btn_a} = b;
        @(posedge clk);
        model_step();
        @(negedge clk);
        {btn_d, btn_x, btn_w, btn_s, btn_a} = 5'b0;
        cmp_all();
    endtask

    task automatic press(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(B_N);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_state", 32'(state), 32'(ST_SHUTDOWN));
        chk("rst_speed", 32'(speed), 32'd0);
        chk("rst_storm_used", 32'(storm_used), 32'd0);
        chk("rst_work", 32'(work_time), 32'd0);
        chk("rst_remind", 32'(remind_time), 32'd0);
        chk("rst_switch", 32'(switch_time), 32'h000010);
        chk("rst_edit", 32'(edit_time), 32'd0);
        chk("rst_alarm", 32'(remind_alarm), 32'd0);
    endtask

    initial begin
        do_reset();
        chk_reset_vals();
        // Reset in the middle of a storm drops everything back.
        step(B_S); step(B_W); step(B_D);
        chk("storm_entry", 32'(state), 32'(ST_STORM));
        press(B_N, 2);
        do_reset();
        chk_reset_vals();

        step(B_S); step(B_W); step(B_A);
        chk("run_entry", 32'(state), 32'(ST_RUN));
        chk("run_speed1", 32'(speed), 32'd1);
        press(B_S, 5);
        chk("speed_sat_hi", 32'(speed), 32'd3);
        press(B_A, 5);
        chk("speed_sat_lo", 32'(speed), 32'd1);

        step(B_W); step(B_W); step(B_D);
        chk("storm_state", 32'(state), 32'(ST_STORM));
        chk("storm_speed", 32'(speed), 32'd3);
        chk("storm_used_set", 32'(storm_used), 32'd1);
        press(B_N, 12);
        chk("storm_timeout_state", 32'(state), 32'(ST_RUN));
        chk("storm_timeout_speed", 32'(speed), 32'd3);
        step(B_W); step(B_W); step(B_D);
        chk("storm_refused", 32'(state), 32'(ST_MENU));

        step(B_W); step(B_X); step(B_D); step(B_X);
        chk("set_hour_entry", 32'(state), 32'(ST_SET_HOUR));
        press(B_A, 25);
        chk("hour_wrap_25", 32'(edit_time[23:16]), 32'h01);
        step(B_S);
        press(B_A, 60);
        chk("min_wrap_60", 32'(edit_time[15:8]), 32'h00);
        step(B_S); step(B_S);
        chk("remind_commit", 32'(remind_time), 32'h010000);
        chk("commit_return", 32'(state), 32'(ST_SHOW_REMIND));

        step(B_X); step(B_A); step(B_S); step(B_A); step(B_W);
        chk("discard_keeps", 32'(remind_time), 32'h010000);
        chk("discard_return", 32'(state), 32'(ST_SHOW_REMIND));
        step(B_X);
        press(B_A, 22);
        chk("hour_23", 32'(edit_time[23:16]), 32'h23);
        step(B_A);
        chk("hour_23_wrap", 32'(edit_time[23:16]), 32'h00);
        step(B_W);

        step(B_X);
        press(B_A, 23);
        step(B_S); step(B_S);
        press(B_A, 3);
        step(B_S);
        chk("remind_3s", 32'(remind_time), 32'h000003);
        step(B_W); step(B_W); step(B_W); step(B_X);
        chk("clean_entry", 32'(state), 32'(ST_CLEAN));
        press(B_N, 8);
        chk("clean_done_state", 32'(state), 32'(ST_STANDBY));
        chk("clean_work_zero", 32'(work_time), 32'd0);
        chk("clean_alarm_zero", 32'(remind_alarm), 32'd0);
        step(B_W); step(B_A);
        press(B_N, 12);
        chk("work_3s", 32'(work_time), 32'h000003);
        chk("alarm_set", 32'(remind_alarm), 32'd1);
        step(B_W | B_S);
        chk("prio_w_over_s", 32'(state), 32'(ST_STANDBY));
        step(B_W); step(B_X);
        press(B_N, 8);
        chk("alarm_cleared", 32'(remind_alarm), 32'd0);
        step(B_X | B_S);
        chk("prio_x_over_s", 32'(state), 32'(ST_SEARCH));

        step(B_S); step(B_X); step(B_S); step(B_S);
        press(B_A, 52);
        step(B_S);
        chk("switch_2s", 32'(switch_time), 32'h000002);
        step(B_W); step(B_W);
`ifdef HOOD_AUTO_OFF_EN
        press(B_N, 8);
        chk("auto_off", 32'(state), 32'(ST_SHUTDOWN));
        step(B_S);
        for (int i = 0; i < 10; i++) begin
            step(B_A);
            press(B_N, 2);
        end
        chk("auto_off_held", 32'(state), 32'(ST_STANDBY));
`else
        press(B_N, 40);
        chk("no_auto_off", 32'(state), 32'(ST_STANDBY));
`endif

        for (int i = 0; i < 2500; i++) begin
            logic [4:0] b;
            b = '0;
            for (int k = 0; k < 5; k++) if ($urandom_range(0, 7) == 0) b[k] = 1'b1;
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
            step(b);
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
